// File: rtl/pu_msp430_scan_pkg.sv
// ---------------------------------------------------------------------------
// pu_msp430_scan_pkg
//
// Shared definitions for the MSP430 scan-mode sequencer:
//   - scan_state_t       : sequencer state encoding (binary, registered)
//   - DEFAULT_UNLOCK_KEY : key word that arms scan entry
//   - SETTLE_CNT_W       : width of the settle-window down-counter
// ---------------------------------------------------------------------------
package pu_msp430_scan_pkg;

    localparam logic [15:0] DEFAULT_UNLOCK_KEY = 16'hA5C3;
    localparam int          SETTLE_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_ENTER = 3'd2,
        ST_SCAN  = 3'd3,
        ST_EXIT  = 3'd4
    } scan_state_t;

endpackage : pu_msp430_scan_pkg

// File: rtl/pu_msp430_sync_cell.sv
// ---------------------------------------------------------------------------
// pu_msp430_sync_cell
//
// Generic N-flop level synchronizer for bringing an asynchronous single-bit
// signal into the clk domain. Output latency is STAGES clk cycles.
//
// Parameters:
//   STAGES    : number of flops in the chain (>= 2)
//
// Ports:
//   clk       in  1  destination clock
//   rst_n     in  1  asynchronous active-low reset, clears every stage
//   d         in  1  asynchronous input
//   q         out 1  synchronized output
// ---------------------------------------------------------------------------
module pu_msp430_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: every synchronizer stage is reset so the chain cannot report a
    // stale request after reset release; flops use non-blocking assignment
    // so the shift happens as one simultaneous register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : pu_msp430_sync_cell

// File: rtl/pu_msp430_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pu_msp430_scan_ctrl
//
// Scan-mode entry/exit sequencer. Produces the global scan mux select and a
// functional-hold qualifier. Entry needs a key unlock followed by a
// synchronized test request; every functional<->scan switch is bracketed by
// a settle window during which func_hold is high and scan_mode is stable.
//
// Parameters:
//   SYNC_STAGES   : synchronizer depth for test_req (>= 2)
//   SETTLE_CYCLES : settle window length in mclk cycles (1..255)
//   UNLOCK_KEY    : key word that arms scan entry
//
// Ports:
//   mclk       in  1   core clock
//   reset_n    in  1   asynchronous active-low reset
//   test_req   in  1   asynchronous, level-sensitive scan request from pad
//   key_valid  in  1   single-cycle strobe qualifying key_data
//   key_data   in  16  unlock key word
//   scan_mode  out 1   scan mux select, 1 = scan path
//   func_hold  out 1   freezes functional FSMs and clock enables
//   armed      out 1   key accepted, waiting for request
//   key_err    out 1   one-cycle pulse after a wrong key in IDLE
// ---------------------------------------------------------------------------
module pu_msp430_scan_ctrl
    import pu_msp430_scan_pkg::*;
#(
    parameter int          SYNC_STAGES   = 2,
    parameter int          SETTLE_CYCLES = 8,
    parameter logic [15:0] UNLOCK_KEY    = DEFAULT_UNLOCK_KEY
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        test_req,
    input  logic        key_valid,
    input  logic [15:0] key_data,
    output logic        scan_mode,
    output logic        func_hold,
    output logic        armed,
    output logic        key_err
);

    // Counter starts at SETTLE_CYCLES-1 and the transition fires on the edge
    // after it reads zero, giving a window of exactly SETTLE_CYCLES cycles.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
        SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t             state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    req_s;
    logic                    cnt_zero;

    pu_msp430_sync_cell #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (mclk),
        .rst_n (reset_n),
        .d     (test_req),
        .q     (req_s)
    );

    assign cnt_zero = (settle_cnt == '0);

    // Outputs are registered alongside the state so each one changes only on
    // the edge that enters the state that owns it; no decode glitches reach
    // the scan muxes.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            scan_mode  <= 1'b0;
            func_hold  <= 1'b0;
            armed      <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            key_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (key_data == UNLOCK_KEY) begin
                            state <= ST_ARMED;
                            armed <= 1'b1;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end

                ST_ARMED: begin
                    // Any key strobe disarms, even when the request arrives
                    // in the same cycle.
                    if (key_valid) begin
                        state <= ST_IDLE;
                        armed <= 1'b0;
                    end else if (req_s) begin
                        state      <= ST_ENTER;
                        armed      <= 1'b0;
                        func_hold  <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                ST_ENTER: begin
                    // A withdrawn request aborts entry before the muxes
                    // switch; the exit window then runs in full.
                    if (!req_s) begin
                        state      <= ST_EXIT;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (cnt_zero) begin
                        state     <= ST_SCAN;
                        scan_mode <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (!req_s) begin
                        state      <= ST_EXIT;
                        scan_mode  <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                ST_EXIT: begin
                    // Request reassertion is ignored here; the sequence
                    // always returns to IDLE and needs a fresh key.
                    if (cnt_zero) begin
                        state     <= ST_IDLE;
                        func_hold <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                default: begin
                    // Unused encodings fall back to the safe functional state.
                    state      <= ST_IDLE;
                    settle_cnt <= '0;
                    scan_mode  <= 1'b0;
                    func_hold  <= 1'b0;
                    armed      <= 1'b0;
                end
            endcase
        end
    end

endmodule : pu_msp430_scan_ctrl

// File: tb/tb_pu_msp430_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pu_msp430_scan_ctrl
//
// Self-checking bench for pu_msp430_scan_ctrl. Two instances: default
// parameters (dut 0) and SYNC_STAGES=3 / SETTLE_CYCLES=1 (dut 1).
// A per-cycle vector table drives one instance at a time and compares all
// outputs one cycle-edge later; the asynchronous reset case is hand-written.
// ---------------------------------------------------------------------------
module tb_pu_msp430_scan_ctrl;

    localparam logic [15:0] KEY = 16'hA5C3;
    localparam logic [15:0] BAD = 16'h1234;

    typedef struct {
        bit          dut;
        logic        kv;
        logic [15:0] kd;
        logic        req;
        logic        exp_sm;
        logic        exp_fh;
        logic        exp_ar;
        logic        exp_ke;
    } vec_t;

    logic        mclk = 1'b0;
    logic        reset_n0, reset_n1;
    logic        test_req0, test_req1;
    logic        key_valid0, key_valid1;
    logic [15:0] key_data0, key_data1;
    logic        scan_mode0, func_hold0, armed0, key_err0;
    logic        scan_mode1, func_hold1, armed1, key_err1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vec_t vecs[$];

    always #5 mclk = ~mclk;

    pu_msp430_scan_ctrl u_dut0 (
        .mclk      (mclk),
        .reset_n   (reset_n0),
        .test_req  (test_req0),
        .key_valid (key_valid0),
        .key_data  (key_data0),
        .scan_mode (scan_mode0),
        .func_hold (func_hold0),
        .armed     (armed0),
        .key_err   (key_err0)
    );

    pu_msp430_scan_ctrl #(
        .SYNC_STAGES   (3),
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .mclk      (mclk),
        .reset_n   (reset_n1),
        .test_req  (test_req1),
        .key_valid (key_valid1),
        .key_data  (key_data1),
        .scan_mode (scan_mode1),
        .func_hold (func_hold1),
        .armed     (armed1),
        .key_err   (key_err1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add(input bit dut, input logic kv, input logic [15:0] kd,
                       input logic req, input logic sm, input logic fh,
                       input logic ar, input logic ke);
        vec_t v;
        v.dut = dut; v.kv = kv; v.kd = kd; v.req = req;
        v.exp_sm = sm; v.exp_fh = fh; v.exp_ar = ar; v.exp_ke = ke;
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, after the edge they belong to has settled.
    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic build_table();
        // Main entry/exit, SETTLE=8, SYNC=2.
        add(0, 1, KEY, 0, 0, 0, 1, 0);                   // armed next cycle
        add(0, 0, 0,   1, 0, 0, 1, 0);                   // sync stage 1
        add(0, 0, 0,   1, 0, 0, 1, 0);                   // req_s rises
        add(0, 0, 0,   1, 0, 1, 0, 0);                   // ENTER, hold rises
        for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0,   1, 1, 1, 0, 0);                   // SCAN, 8 after hold
        add(0, 0, 0,   0, 1, 1, 0, 0);                   // drop request
        add(0, 0, 0,   0, 1, 1, 0, 0);
        add(0, 0, 0,   0, 0, 1, 0, 0);                   // EXIT
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);                   // IDLE, 8 after

        // Wrong key in IDLE, then a request without a key.
        add(0, 1, BAD, 0, 0, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 0);

        // Key strobe in the same cycle the FSM first sees req_s: disarm wins.
        add(0, 1, KEY, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1, KEY, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 0);

        // Three-cycle request pulse aborts ENTER: hold lasts 3 + 8 cycles.
        add(0, 1, KEY, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);

        // SETTLE=1, SYNC=3 instance.
        add(1, 1, KEY, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0,   1, 0, 1, 0, 0);                   // hold at sync+1
        add(1, 0, 0,   1, 1, 1, 0, 0);                   // scan 1 later
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0,   0, 0, 1, 0, 0);                   // EXIT
        add(1, 0, 0,   0, 0, 0, 0, 0);                   // IDLE
        add(1, 0, 0,   0, 0, 0, 0, 0);
    endtask

    initial begin
        bit seen;

        reset_n0 = 1'b0; reset_n1 = 1'b0;
        test_req0 = 1'b0; test_req1 = 1'b0;
        key_valid0 = 1'b0; key_valid1 = 1'b0;
        key_data0 = '0; key_data1 = '0;
        build_table();

        repeat (2) step();
        check("rst.outs0", {scan_mode0, func_hold0, armed0, key_err0}, 4'b0);
        check("rst.outs1", {scan_mode1, func_hold1, armed1, key_err1}, 4'b0);
        reset_n0 = 1'b1; reset_n1 = 1'b1;
        step();
        check("post_rst.outs0", {scan_mode0, func_hold0, armed0, key_err0}, 4'b0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            test_req0  = v.dut ? 1'b0 : v.req;
            key_valid0 = v.dut ? 1'b0 : v.kv;
            key_data0  = v.dut ? 16'h0 : v.kd;
            test_req1  = v.dut ? v.req : 1'b0;
            key_valid1 = v.dut ? v.kv : 1'b0;
            key_data1  = v.dut ? v.kd : 16'h0;
            step();
            if (!v.dut) begin
                check($sformatf("v%0d.d0.outs(sm,fh,ar,ke)", i),
                      {scan_mode0, func_hold0, armed0, key_err0},
                      {v.exp_sm, v.exp_fh, v.exp_ar, v.exp_ke});
            end else begin
                check($sformatf("v%0d.d1.outs(sm,fh,ar,ke)", i),
                      {scan_mode1, func_hold1, armed1, key_err1},
                      {v.exp_sm, v.exp_fh, v.exp_ar, v.exp_ke});
            end
            if (scan_mode0 && !func_hold0)
                check($sformatf("v%0d.d0.scan_implies_hold", i), 0, 1);
            if (scan_mode1 && !func_hold1)
                check($sformatf("v%0d.d1.scan_implies_hold", i), 0, 1);
        end
        test_req1 = 1'b0; key_valid1 = 1'b0;

        // Asynchronous reset while in SCAN.
        key_valid0 = 1'b1; key_data0 = KEY; test_req0 = 1'b0;
        step();
        key_valid0 = 1'b0; test_req0 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            seen = scan_mode0;
        end
        check("reach_scan", seen, 1);
        #2;
        reset_n0 = 1'b0;
        #1;
        check("async_rst.scan_mode", scan_mode0, 0);
        check("async_rst.func_hold", func_hold0, 0);
        step();
        reset_n0 = 1'b1;
        repeat (6) step();
        check("after_rst.func_hold", func_hold0, 0);
        check("after_rst.armed", armed0, 0);
        key_valid0 = 1'b1; key_data0 = KEY;
        step();
        key_valid0 = 1'b0;
        check("after_rst.rearm", armed0, 1);
        step();
        check("after_rst.enter_hold", func_hold0, 1);
        test_req0 = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_pu_msp430_scan_ctrl
